// File: rtl/mem_request_ctrl_pkg.sv
// mem_request_ctrl_pkg
//   Shared definitions for the main_memory initiator controller:
//   memory word geometry, the default access latency and the FSM state type.
package mem_request_ctrl_pkg;

   // One memory access covers four consecutive byte entries.
   localparam int MEM_DATA_SIZE   = 8;
   localparam int MEM_DATA_WIDTH  = 4 * MEM_DATA_SIZE;
   localparam int MEM_LATENCY_DEF = 5;

   typedef enum logic [1:0] {
      MRC_IDLE = 2'd0,
      MRC_WAIT = 2'd1,
      MRC_RESP = 2'd2
   } mrc_state_e;

endpackage

// File: rtl/mem_request_ctrl.sv
// mem_request_ctrl
//   Initiator-side controller in front of the combinational main_memory array.
//   Accepts one load/store at a time, holds it on the memory bus for
//   MEM_LATENCY cycles, then returns a one-cycle response pulse.
//
// Ports
//   clk               rising-edge clock
//   reset             asynchronous, active-low reset
//   req_valid/ready   request handshake (ready is registered)
//   req_write         1 = store, 0 = load
//   req_addr          byte address (bits [1:0] ignored)
//   req_wdata         store data
//   rsp_valid         one-cycle completion pulse
//   rsp_write         write flag of the completing request
//   rsp_rdata         load data, held across store responses
//   busy              controller not in IDLE
//   mem_addr, mem_data_to_write, mem_wrt_en   to main_memory
//   mem_data_to_read  from main_memory
module mem_request_ctrl
   import mem_request_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = MEM_DATA_WIDTH,
   parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic                  rsp_write,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data_to_write,
   output logic                  mem_wrt_en,
   input  logic [DATA_WIDTH-1:0] mem_data_to_read
);

   localparam logic [7:0] LAT_M1 = 8'(MEM_LATENCY - 1);

   mrc_state_e            state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  wr_q, wr_d;
   logic                  ready_d, rv_d, rw_d, busy_d, we_d;
   logic [DATA_WIDTH-1:0] rd_d, wd_d;
   logic [ADDR_WIDTH-1:0] addr_d;

   // Every output is registered, so the next-state logic computes the value
   // each output takes in the cycle after the edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      ready_d = 1'b0;
      rv_d    = 1'b0;
      rw_d    = rsp_write;
      rd_d    = rsp_rdata;
      busy_d  = 1'b1;
      addr_d  = mem_addr;
      wd_d    = mem_data_to_write;
      we_d    = 1'b0;
      case (state_q)
         MRC_IDLE: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
            addr_d  = '0;
            wd_d    = '0;
            if (req_valid && req_ready) begin
               state_d = MRC_WAIT;
               cnt_d   = LAT_M1;
               wr_d    = req_write;
               ready_d = 1'b0;
               busy_d  = 1'b1;
               addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
               wd_d    = req_wdata;
               // With a one-cycle latency the first WAIT cycle is also the last.
               we_d    = req_write && (MEM_LATENCY == 1);
            end
         end
         MRC_WAIT: begin
            if (cnt_q == 8'd0) begin
               state_d = MRC_RESP;
               rv_d    = 1'b1;
               rw_d    = wr_q;
               if (!wr_q)
                  rd_d = mem_data_to_read;
               addr_d  = '0;
               wd_d    = '0;
            end else begin
               cnt_d = cnt_q - 8'd1;
               // Pulse the write enable into the cycle where the counter hits 0.
               we_d  = wr_q && (cnt_q == 8'd1);
            end
         end
         MRC_RESP: begin
            state_d = MRC_IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            addr_d  = '0;
            wd_d    = '0;
         end
         default: begin
            state_d = MRC_IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            addr_d  = '0;
            wd_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q           <= MRC_IDLE;
         cnt_q             <= '0;
         wr_q              <= 1'b0;
         req_ready         <= 1'b0;
         rsp_valid         <= 1'b0;
         rsp_write         <= 1'b0;
         rsp_rdata         <= '0;
         busy              <= 1'b0;
         mem_addr          <= '0;
         mem_data_to_write <= '0;
         mem_wrt_en        <= 1'b0;
      end else begin
         state_q           <= state_d;
         cnt_q             <= cnt_d;
         wr_q              <= wr_d;
         req_ready         <= ready_d;
         rsp_valid         <= rv_d;
         rsp_write         <= rw_d;
         rsp_rdata         <= rd_d;
         busy              <= busy_d;
         mem_addr          <= addr_d;
         mem_data_to_write <= wd_d;
         mem_wrt_en        <= we_d;
      end
   end

endmodule

// File: tb/tb_mem_request_ctrl.sv
// tb_mem_request_ctrl
//   Two controllers (latency 5 and latency 1) in front of byte-array memory
//   models. A posedge process records accepted requests into per-instance
//   scoreboards with their expected responses; a negedge monitor compares the
//   bus and response outputs against the request timeline.
module tb_mem_request_ctrl;

   localparam int LAT0 = 5;
   localparam int LAT1 = 1;
   localparam int MSZ  = 8192;

   typedef struct {
      int          edge_n;
      bit          w;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] rd;
   } acc_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_write [2];
   logic [31:0] req_addr [2];
   logic [31:0] req_wdata [2];
   logic        rsp_valid [2];
   logic        rsp_write [2];
   logic [31:0] rsp_rdata [2];
   logic        busy [2];
   logic [31:0] mem_addr [2];
   logic [31:0] mem_data_to_write [2];
   logic        mem_wrt_en [2];
   logic [31:0] mem_data_to_read [2];

   logic [7:0]  main_mem [2][MSZ];
   logic [7:0]  gold [2][MSZ];
   bit          mem_inited;
   acc_t        sb [2][$];
   logic [31:0] last_rd [2];
   int          cyc = 0;
   int          since_rst = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   mem_request_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT0)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_write(rsp_write[0]), .rsp_rdata(rsp_rdata[0]),
      .busy(busy[0]), .mem_addr(mem_addr[0]), .mem_data_to_write(mem_data_to_write[0]),
      .mem_wrt_en(mem_wrt_en[0]), .mem_data_to_read(mem_data_to_read[0]));

   mem_request_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT1)) dut1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_write(rsp_write[1]), .rsp_rdata(rsp_rdata[1]),
      .busy(busy[1]), .mem_addr(mem_addr[1]), .mem_data_to_write(mem_data_to_write[1]),
      .mem_wrt_en(mem_wrt_en[1]), .mem_data_to_read(mem_data_to_read[1]));

   function automatic int lat(input int i);
      return (i == 0) ? LAT0 : LAT1;
   endfunction

   function automatic logic [7:0] init_byte(input int a);
      return 8'(a * 29 + 7);
   endfunction

   function automatic logic [12:0] ix(input logic [31:0] a, input int j);
      return a[12:0] + 13'(j);
   endfunction

   function automatic logic [31:0] gold_word(input int i, input logic [31:0] a);
      logic [12:0] b;
      b = {a[12:2], 2'b00};
      return {gold[i][b + 13'd3], gold[i][b + 13'd2], gold[i][b + 13'd1], gold[i][b]};
   endfunction

   task automatic chk(input string nm, input int i, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d cyc%0d: got %h expected %h", nm, i, cyc, act, exp);
      end
   endtask

   // main_memory models: combinational read, write on the clock edge.
   for (genvar g = 0; g < 2; g++) begin : g_rd
      assign mem_data_to_read[g] = {main_mem[g][ix(mem_addr[g], 3)], main_mem[g][ix(mem_addr[g], 2)],
                                    main_mem[g][ix(mem_addr[g], 1)], main_mem[g][ix(mem_addr[g], 0)]};
   end

   always @(posedge clk) begin
      if (!mem_inited) begin
         for (int i = 0; i < 2; i++)
            for (int a = 0; a < MSZ; a++)
               main_mem[i][a] <= init_byte(a);
         mem_inited <= 1'b1;
      end else begin
         for (int i = 0; i < 2; i++)
            if (mem_wrt_en[i])
               for (int j = 0; j < 4; j++)
                  main_mem[i][ix(mem_addr[i], j)] <= mem_data_to_write[i][8*j +: 8];
      end
   end

   // Scoreboard producer: record each accepted request with its expected load data.
   always @(posedge clk) begin
      acc_t r;
      cyc       <= cyc + 1;
      since_rst <= reset ? since_rst + 1 : 0;
      for (int i = 0; i < 2; i++) begin
         if (reset && req_valid[i] && req_ready[i]) begin
            r.edge_n = cyc + 1;
            r.w      = req_write[i];
            r.a      = req_addr[i];
            r.d      = req_wdata[i];
            r.rd     = gold_word(i, req_addr[i]);
            sb[i].push_back(r);
         end
      end
   end

   // Monitor: cycle k of a request (k=1 is the cycle after the accepting edge)
   // is a bus cycle for k<=L and the response cycle for k=L+1.
   acc_t        mt;
   int          mk;
   int          ml;
   logic [67:0] e_bus;
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset) begin
            chk("reset_outputs", i,
                128'({req_ready[i], busy[i], rsp_valid[i], mem_wrt_en[i], mem_addr[i],
                      mem_data_to_write[i], rsp_write[i], rsp_rdata[i]}), '0);
            sb[i].delete();
            last_rd[i] = '0;
         end else begin
            if (sb[i].size() != 0) begin
               mt = sb[i][0];
               mk = cyc - mt.edge_n + 1;
               ml = lat(i);
               if (mk <= ml) begin
                  e_bus = {1'b0, 1'b1, 1'b0, (mt.w && mk == ml), mt.a[31:2], 2'b00, mt.d};
               end else begin
                  e_bus = {1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0};
                  chk("rsp_write", i, 128'(rsp_write[i]), 128'(mt.w));
                  chk("rsp_rdata", i, 128'(rsp_rdata[i]), 128'(mt.w ? last_rd[i] : mt.rd));
                  if (mt.w) begin
                     for (int j = 0; j < 4; j++)
                        gold[i][{mt.a[12:2], 2'b00} + 13'(j)] = mt.d[8*j +: 8];
                  end else begin
                     last_rd[i] = mt.rd;
                  end
                  void'(sb[i].pop_front());
               end
            end else begin
               e_bus = {(since_rst >= 1), 1'b0, 1'b0, 1'b0, 32'd0, 32'd0};
            end
            chk("bus", i, 128'({req_ready[i], busy[i], rsp_valid[i], mem_wrt_en[i],
                                mem_addr[i], mem_data_to_write[i]}), 128'(e_bus));
         end
      end
   end

   // Holds the request until accepted; returns the accepting edge number.
   task automatic issue(input int i, input bit w, input logic [31:0] a,
                        input logic [31:0] d, output int e);
      bit took;
      req_write[i] = w;
      req_addr[i]  = a;
      req_wdata[i] = d;
      req_valid[i] = 1'b1;
      e = -1;
      for (int n = 0; n < 60; n++) begin
         @(posedge clk);
         took = reset && req_ready[i];
         #1;
         if (took) begin
            e = cyc;
            break;
         end
      end
      @(negedge clk);
      req_valid[i] = 1'b0;
      if (e < 0) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout inst%0d addr %h: got no accept expected accept", i, a);
      end
   endtask

   int          e1, e2;
   int          bad;
   logic [31:0] tw;

   initial begin
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0;
         req_write[i] = 1'b0;
         req_addr[i]  = '0;
         req_wdata[i] = '0;
         last_rd[i]   = '0;
         for (int a = 0; a < MSZ; a++)
            gold[i][a] = init_byte(a);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Load from 0x10, then store/load round trip at 0x20.
      issue(0, 1'b0, 32'h0000_0010, 32'h0, e1);
      issue(0, 1'b1, 32'h0000_0020, 32'hA5A5_5A5A, e1);
      issue(0, 1'b0, 32'h0000_0020, 32'h0, e1);
      // Unaligned load address is aligned on the bus.
      issue(0, 1'b0, 32'h0000_1003, 32'h1234_5678, e1);
      repeat (8) @(negedge clk);

      // Back-to-back requests with valid held high.
      issue(0, 1'b0, 32'h0000_0100, 32'h0, e1);
      issue(0, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, e2);
      checks++;
      if (e2 - e1 != LAT0 + 2) begin
         errors++;
         $display("FAIL throughput_l5: got %0d expected %0d", e2 - e1, LAT0 + 2);
      end
      repeat (8) @(negedge clk);

      // Store to 0x40 aborted by reset in its third WAIT cycle.
      issue(0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, e1);
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      #1 chk("reset_immediate", 0, 128'({req_ready[0], busy[0], rsp_valid[0], mem_wrt_en[0],
                                          mem_addr[0]}), '0);
      @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      repeat (3) @(negedge clk);
      tw = {main_mem[0][16'h43], main_mem[0][16'h42], main_mem[0][16'h41], main_mem[0][16'h40]};
      chk("aborted_store_mem", 0, 128'(tw),
          128'({init_byte(32'h43), init_byte(32'h42), init_byte(32'h41), init_byte(32'h40)}));

      // Latency-1 build: loads and a store, back to back.
      issue(1, 1'b0, 32'h0000_0008, 32'h0, e1);
      issue(1, 1'b1, 32'h0000_000C, 32'h0BAD_C0DE, e2);
      checks++;
      if (e2 - e1 != LAT1 + 2) begin
         errors++;
         $display("FAIL throughput_l1: got %0d expected %0d", e2 - e1, LAT1 + 2);
      end
      issue(1, 1'b0, 32'h0000_000C, 32'h0, e1);
      repeat (4) @(negedge clk);

      // Randomized traffic on both builds.
      for (int i = 0; i < 2; i++) begin
         for (int n = 0; n < 30; n++) begin
            issue(i, 1'($urandom_range(0, 1)), 32'($urandom_range(0, MSZ - 1)), $urandom, e1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end
      repeat (12) @(negedge clk);

      for (int i = 0; i < 2; i++) begin
         chk("drain", i, 128'(sb[i].size()), '0);
         bad = 0;
         for (int a = 0; a < MSZ; a++)
            if (main_mem[i][a] !== gold[i][a])
               bad++;
         chk("mem_image", i, 128'(bad), '0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
